// File: rtl/freq_meter_pkg.sv
// Shared constants, FSM encoding and sizing helper for the gated BCD frequency meter.
package freq_meter_pkg;

    localparam int               DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_COUNT = 2'd1,
        ST_LATCH = 2'd2
    } fsm_state_t;

    // Gate timer counts 0..gate_cycles-1; never narrower than one bit.
    function automatic int timer_width(input int gate_cycles);
        return (gate_cycles > 2) ? $clog2(gate_cycles) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_bcd_if.sv
// Measurement-side bundle: control/signal inputs, latched BCD result and FSM debug view.
interface freq_meter_bcd_if
    import freq_meter_pkg::*;
#(
    parameter int NUM_DIGITS = 6
);
    logic                          en;
    logic                          sig_in;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out;
    logic                          valid;
    logic                          overflow;
    fsm_state_t                    dbg_state;

    // valid is a one-cycle strobe with no ready: bcd_out/overflow are updated in the
    // same cycle valid is high and hold until the next strobe, so the consumer may
    // sample them on the strobe or at any later time; there is no backpressure.
    modport master (
        output en, sig_in,
        input  bcd_out, valid, overflow, dbg_state
    );

    modport slave (
        input  en, sig_in,
        output bcd_out, valid, overflow, dbg_state
    );
endinterface

// File: rtl/freq_meter_bcd_digit_counter.sv
// One packed-BCD digit: clear, increment on carry-in with 9->0 wrap, or hold on saturation.
module bcd_digit_counter
    import freq_meter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic               sat,
    output logic [DIGIT_W-1:0] q,
    output logic [DIGIT_W-1:0] q_next,
    output logic               carry_out
);

    logic [DIGIT_W-1:0] base;

    // clr and inc together give a fresh digit of 1, so a restart cycle can still count.
    always_comb begin
        base      = clr ? '0 : q;
        carry_out = inc && (base == BCD_MAX);
        q_next    = base;
        if (inc && !sat) begin
            q_next = carry_out ? '0 : base + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency counter: synchronized rising edges of sig_in counted in BCD over a fixed clk window.
module freq_meter_bcd
    import freq_meter_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int GATE_CYCLES = CLK_FREQ_HZ,
    parameter int NUM_DIGITS  = 6
)(
    input  logic             clk,
    input  logic             rst,
    freq_meter_bcd_if.slave  bus
);

    localparam int             TW         = timer_width(GATE_CYCLES);
    localparam int             BW         = DIGIT_W * NUM_DIGITS;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(GATE_CYCLES - 1);

    if (GATE_CYCLES < 2 || CLK_FREQ_HZ < 1) begin : g_bad_param
        $error("freq_meter_bcd: GATE_CYCLES must be >= 2 and CLK_FREQ_HZ positive");
    end

    fsm_state_t              state, state_next;
    logic                    s1, s2, s3, sig_edge;
    logic [TW-1:0]           timer;
    logic                    ovf, ovf_next;
    logic                    counting, terminal, clr_cnt, sat;
    logic [NUM_DIGITS-1:0]   nine_base, inc_vec, carry;
    logic [BW-1:0]           q_all, q_next_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3} <= 3'b000;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;
    assign counting = (state == ST_COUNT) && bus.en;
    assign terminal = counting && (timer == TIMER_LAST);
    assign clr_cnt  = (state != ST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ARM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ARM:   state_next = ST_COUNT;
            ST_COUNT: if (terminal) state_next = ST_LATCH;
            ST_LATCH: state_next = ST_COUNT;
            default:  state_next = ST_ARM;
        endcase
    end

    // Ripple enables come from registered digits, so the carry chain has no feedback.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nine_base[k] = !clr_cnt && (q_all[DIGIT_W*k +: DIGIT_W] == BCD_MAX);
        end
        inc_vec[0] = sig_edge && (counting || (state == ST_LATCH));
        for (int k = 1; k < NUM_DIGITS; k++) begin
            inc_vec[k] = inc_vec[k-1] && nine_base[k-1];
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit_counter u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_cnt),
            .inc       (inc_vec[k]),
            .sat       (sat),
            .q         (q_all[DIGIT_W*k +: DIGIT_W]),
            .q_next    (q_next_all[DIGIT_W*k +: DIGIT_W]),
            .carry_out (carry[k])
        );
    end

    // Every digit rolling over at once means the count was all nines: hold it there.
    assign sat      = &carry;
    assign ovf_next = (state == ST_COUNT) ? (ovf | sat) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            timer        <= '0;
            ovf          <= 1'b0;
            bus.bcd_out  <= '0;
            bus.overflow <= 1'b0;
            bus.valid    <= 1'b0;
        end else begin
            ovf       <= ovf_next;
            bus.valid <= terminal;
            if (clr_cnt || terminal) begin
                timer <= '0;
            end else if (counting) begin
                timer <= timer + TW'(1);
            end
            if (terminal) begin
                bus.bcd_out  <= q_next_all;
                bus.overflow <= ovf_next;
            end
        end
    end

    assign bus.dbg_state = state;

endmodule
